// File: rtl/bulls_cows_match_if.sv
// Switch/button front end and display-side signals of the Bulls & Cows match controller.
interface bulls_cows_match_if #(
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned DIGIT_W      = 4,
   parameter int unsigned SCORE_TO_WIN = 3
);
   localparam int unsigned CW = $clog2(DIGITS + 1);
   localparam int unsigned SW = $clog2(SCORE_TO_WIN + 1);

   logic [DIGITS*DIGIT_W-1:0] guess;
   logic                      confirm;
   logic [2:0]                state;
   logic [CW-1:0]             bulls;
   logic [CW-1:0]             cows;
   logic [SW-1:0]             score_j1;
   logic [SW-1:0]             score_j2;
   logic                      starter;
   logic                      err;

   modport master (
      output guess, confirm,
      input  state, bulls, cows, score_j1, score_j2, starter, err
   );

   modport slave (
      input  guess, confirm,
      output state, bulls, cows, score_j1, score_j2, starter, err
   );
endinterface

// File: rtl/bulls_cows_match.sv
// Two-player Bulls & Cows match controller: secret entry, validated guesses,
// bulls/cows scoring and per-player round wins until SCORE_TO_WIN is reached.
module bulls_cows_match #(
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned DIGIT_W      = 4,
   parameter int unsigned BASE         = 10,
   parameter int unsigned SCORE_TO_WIN = 3
) (
   input logic               clock,
   input logic               reset,
   bulls_cows_match_if.slave bus
);
   localparam int unsigned CW = $clog2(DIGITS + 1);
   localparam int unsigned SW = $clog2(SCORE_TO_WIN + 1);
   localparam int unsigned GW = DIGITS * DIGIT_W;

   typedef enum logic [2:0] {
      SECRET_J1 = 3'd0,
      SECRET_J2 = 3'd1,
      GUESS_J1  = 3'd2,
      GUESS_J2  = 3'd3,
      RESULT_J1 = 3'd4,
      RESULT_J2 = 3'd5,
      ROUND_WIN = 3'd6,
      MATCH_END = 3'd7
   } state_t;

   state_t          state_q, state_d;
   logic            confirm_q, cpulse;
   logic [GW-1:0]   secret_j1, secret_j2, target;
   logic [CW-1:0]   bulls_q, cows_q, bulls_c, cows_c;
   logic [SW-1:0]   score_j1_q, score_j2_q;
   logic            starter_q, err_q;
   logic            code_ok, all_bulls, match_won;
   logic            ld_s1, ld_s2, ld_eval, err_we, err_d, win_j1, win_j2, new_round;

   assign cpulse = bus.confirm & ~confirm_q;

   // Button edge detector; it follows the level even in reset so a press held
   // across reset release is not taken as a new press.
   always_ff @(posedge clock) begin
      confirm_q <= bus.confirm;
   end

   // Code validity: every digit below BASE and all digits pairwise distinct.
   always_comb begin
      code_ok = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (32'(bus.guess[i*DIGIT_W +: DIGIT_W]) >= BASE) code_ok = 1'b0;
         for (int unsigned j = i + 1; j < DIGITS; j++) begin
            if (bus.guess[i*DIGIT_W +: DIGIT_W] == bus.guess[j*DIGIT_W +: DIGIT_W]) code_ok = 1'b0;
         end
      end
   end

   // Bulls/cows of the current guess against the opponent's secret.
   always_comb begin
      target  = (state_q == GUESS_J1) ? secret_j2 : secret_j1;
      bulls_c = '0;
      cows_c  = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         for (int unsigned j = 0; j < DIGITS; j++) begin
            if (bus.guess[i*DIGIT_W +: DIGIT_W] == target[j*DIGIT_W +: DIGIT_W]) begin
               if (i == j) bulls_c = bulls_c + CW'(1);
               else        cows_c  = cows_c + CW'(1);
            end
         end
      end
   end

   assign all_bulls = (bulls_c == CW'(DIGITS));
   assign match_won = (score_j1_q == SW'(SCORE_TO_WIN)) || (score_j2_q == SW'(SCORE_TO_WIN));

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= SECRET_J1;
      else       state_q <= state_d;
   end

   // Next-state logic, advancing only on a confirm press.
   always_comb begin
      state_d = state_q;
      if (cpulse) begin
         case (state_q)
            SECRET_J1: if (code_ok) state_d = SECRET_J2;
            SECRET_J2: if (code_ok) state_d = starter_q ? GUESS_J2 : GUESS_J1;
            GUESS_J1:  if (code_ok) state_d = all_bulls ? ROUND_WIN : RESULT_J1;
            GUESS_J2:  if (code_ok) state_d = all_bulls ? ROUND_WIN : RESULT_J2;
            RESULT_J1: state_d = GUESS_J2;
            RESULT_J2: state_d = GUESS_J1;
            ROUND_WIN: state_d = match_won ? MATCH_END : SECRET_J1;
            default:   state_d = state_q;
         endcase
      end
   end

   // Datapath strobes decoded from state and the confirm press.
   always_comb begin
      ld_s1     = 1'b0;
      ld_s2     = 1'b0;
      ld_eval   = 1'b0;
      err_we    = 1'b0;
      err_d     = 1'b0;
      win_j1    = 1'b0;
      win_j2    = 1'b0;
      new_round = 1'b0;
      if (cpulse) begin
         case (state_q)
            SECRET_J1: begin ld_s1 = code_ok; err_we = 1'b1; err_d = ~code_ok; end
            SECRET_J2: begin ld_s2 = code_ok; err_we = 1'b1; err_d = ~code_ok; end
            GUESS_J1: begin
               ld_eval = code_ok; err_we = 1'b1; err_d = ~code_ok;
               win_j1  = code_ok & all_bulls;
            end
            GUESS_J2: begin
               ld_eval = code_ok; err_we = 1'b1; err_d = ~code_ok;
               win_j2  = code_ok & all_bulls;
            end
            ROUND_WIN: new_round = ~match_won;
            default: ;
         endcase
      end
   end

   // Secrets, result, error flag, scores and starter.
   always_ff @(posedge clock) begin
      if (reset) begin
         secret_j1  <= '0;
         secret_j2  <= '0;
         bulls_q    <= '0;
         cows_q     <= '0;
         score_j1_q <= '0;
         score_j2_q <= '0;
         starter_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (ld_s1) secret_j1 <= bus.guess;
         if (ld_s2) secret_j2 <= bus.guess;
         if (err_we) err_q <= err_d;
         if (ld_eval) begin
            bulls_q <= bulls_c;
            cows_q  <= cows_c;
         end
         if (win_j1 && score_j1_q != SW'(SCORE_TO_WIN)) score_j1_q <= score_j1_q + SW'(1);
         if (win_j2 && score_j2_q != SW'(SCORE_TO_WIN)) score_j2_q <= score_j2_q + SW'(1);
         if (new_round) begin
            starter_q <= ~starter_q;
            bulls_q   <= '0;
            cows_q    <= '0;
            err_q     <= 1'b0;
         end
      end
   end

   assign bus.state    = state_q;
   assign bus.bulls    = bulls_q;
   assign bus.cows     = cows_q;
   assign bus.score_j1 = score_j1_q;
   assign bus.score_j2 = score_j2_q;
   assign bus.starter  = starter_q;
   assign bus.err      = err_q;
endmodule

// File: tb/tb_bulls_cows_match.sv
// Bench for bulls_cows_match: rule-level reference model checked every cycle,
// plus hand-computed expectations along a scripted match.
module tb_bulls_cows_match;
   localparam int unsigned DIGITS  = 4;
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned BASE    = 10;
   localparam int unsigned STW     = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   bulls_cows_match_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .SCORE_TO_WIN(STW)) bus ();

   bulls_cows_match #(
      .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .BASE(BASE), .SCORE_TO_WIN(STW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int dig(input logic [15:0] c, input int i);
      return int'(c[i*4 +: 4]);
   endfunction

   function automatic bit m_valid(input logic [15:0] c);
      for (int i = 0; i < 4; i++) begin
         if (dig(c, i) >= int'(BASE)) return 1'b0;
         for (int j = 0; j < 4; j++)
            if (i != j && dig(c, i) == dig(c, j)) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic int m_bulls(input logic [15:0] g, input logic [15:0] s);
      int n = 0;
      for (int i = 0; i < 4; i++) if (dig(g, i) == dig(s, i)) n++;
      return n;
   endfunction

   function automatic int m_cows(input logic [15:0] g, input logic [15:0] s);
      int n = 0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (i != j && dig(g, i) == dig(s, j)) n++;
      return n;
   endfunction

   int          m_state = 0, m_bulls_v = 0, m_cows_v = 0, m_s1 = 0, m_s2 = 0;
   int          m_starter = 0, m_err = 0;
   logic [15:0] m_sec1 = '0, m_sec2 = '0;
   logic        m_prev = 1'b0;
   bit          m_ok = 1'b0;

   always @(posedge clock) begin
      m_prev <= bus.confirm;
      if (reset) begin
         m_ok <= 1'b1;
         m_state <= 0; m_bulls_v <= 0; m_cows_v <= 0; m_s1 <= 0; m_s2 <= 0;
         m_starter <= 0; m_err <= 0; m_sec1 <= '0; m_sec2 <= '0;
      end else if (bus.confirm && !m_prev) begin
         case (m_state)
            0, 1: begin
               if (m_valid(bus.guess)) begin
                  m_err <= 0;
                  if (m_state == 0) begin m_sec1 <= bus.guess; m_state <= 1; end
                  else begin m_sec2 <= bus.guess; m_state <= (m_starter == 0) ? 2 : 3; end
               end else m_err <= 1;
            end
            2, 3: begin
               if (m_valid(bus.guess)) begin
                  m_err     <= 0;
                  m_bulls_v <= m_bulls(bus.guess, (m_state == 2) ? m_sec2 : m_sec1);
                  m_cows_v  <= m_cows(bus.guess, (m_state == 2) ? m_sec2 : m_sec1);
                  if (m_bulls(bus.guess, (m_state == 2) ? m_sec2 : m_sec1) == 4) begin
                     m_state <= 6;
                     if (m_state == 2 && m_s1 < int'(STW)) m_s1 <= m_s1 + 1;
                     if (m_state == 3 && m_s2 < int'(STW)) m_s2 <= m_s2 + 1;
                  end else m_state <= (m_state == 2) ? 4 : 5;
               end else m_err <= 1;
            end
            4: m_state <= 3;
            5: m_state <= 2;
            6: begin
               if (m_s1 == int'(STW) || m_s2 == int'(STW)) m_state <= 7;
               else begin
                  m_state <= 0; m_starter <= 1 - m_starter;
                  m_bulls_v <= 0; m_cows_v <= 0; m_err <= 0;
               end
            end
            default: ;
         endcase
      end
   end

   // Compare DUT against the model on every falling edge once reset has been seen.
   always @(negedge clock) begin
      if (m_ok) begin
         check("state",    int'(bus.state),    m_state);
         check("bulls",    int'(bus.bulls),    m_bulls_v);
         check("cows",     int'(bus.cows),     m_cows_v);
         check("score_j1", int'(bus.score_j1), m_s1);
         check("score_j2", int'(bus.score_j2), m_s2);
         check("starter",  int'(bus.starter),  m_starter);
         check("err",      int'(bus.err),      m_err);
      end
   end

   // ---------------- stimulus ----------------
   task automatic press(input logic [15:0] code);
      @(negedge clock);
      bus.guess   = code;
      bus.confirm = 1'b1;
      @(negedge clock);
      bus.confirm = 1'b0;
      @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      bus.guess   = '0;
      bus.confirm = 1'b0;
      reset       = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("lit_reset_state", int'(bus.state), 0);
      check("lit_reset_score", int'(bus.score_j1) + int'(bus.score_j2), 0);

      // Round 1: result evaluation for both players.
      press(16'h1234);
      press(16'h5678);
      check("lit_guess_j1_state", int'(bus.state), 2);
      press(16'h8765);
      check("lit_r1_state", int'(bus.state), 4);
      check("lit_r1_bulls", int'(bus.bulls), 0);
      check("lit_r1_cows",  int'(bus.cows), 4);
      check("lit_r1_err",   int'(bus.err), 0);
      press(16'h0000);
      check("lit_to_guess_j2", int'(bus.state), 3);
      press(16'h1243);
      check("lit_r2_state", int'(bus.state), 5);
      check("lit_r2_bulls", int'(bus.bulls), 2);
      check("lit_r2_cows",  int'(bus.cows), 2);
      press(16'h0000);
      press(16'h5678);
      check("lit_win1_state", int'(bus.state), 6);
      check("lit_win1_bulls", int'(bus.bulls), 4);
      check("lit_win1_score", int'(bus.score_j1), 1);
      press(16'h0000);
      check("lit_newround_state",   int'(bus.state), 0);
      check("lit_newround_starter", int'(bus.starter), 1);
      check("lit_newround_bulls",   int'(bus.bulls), 0);

      // Round 2: invalid secrets, then J2 starts and wins.
      press(16'h1123);
      check("lit_repeat_err",   int'(bus.err), 1);
      check("lit_repeat_state", int'(bus.state), 0);
      press(16'h12A4);
      check("lit_digit10_err",   int'(bus.err), 1);
      check("lit_digit10_state", int'(bus.state), 0);
      press(16'h0987);
      check("lit_valid_err",   int'(bus.err), 0);
      check("lit_valid_state", int'(bus.state), 1);
      press(16'h4321);
      check("lit_j2_starts", int'(bus.state), 3);
      @(negedge clock);
      bus.guess = 16'h0987;
      repeat (3) @(negedge clock);
      check("lit_no_press_state", int'(bus.state), 3);
      press(16'h0987);
      check("lit_win2_score_j2", int'(bus.score_j2), 1);
      press(16'h0000);
      check("lit_round3_starter", int'(bus.starter), 0);

      // Round 3: held confirm gives one press; J1 wins the match.
      @(negedge clock);
      bus.guess   = 16'h1234;
      bus.confirm = 1'b1;
      repeat (20) @(negedge clock);
      bus.confirm = 1'b0;
      @(negedge clock);
      check("lit_hold_state", int'(bus.state), 1);
      press(16'h5678);
      press(16'h8765);
      press(16'h0000);
      press(16'h9999);
      check("lit_bad_guess_err",   int'(bus.err), 1);
      check("lit_bad_guess_state", int'(bus.state), 3);
      check("lit_bad_guess_cows",  int'(bus.cows), 4);
      press(16'h1243);
      press(16'h0000);
      press(16'h5678);
      check("lit_match_score_j1", int'(bus.score_j1), 2);
      press(16'h0000);
      check("lit_match_end", int'(bus.state), 7);
      press(16'h1234);
      press(16'h5678);
      check("lit_match_hold_state", int'(bus.state), 7);
      check("lit_match_hold_score", int'(bus.score_j1), 2);

      // Reset during RESULT_J2 with score_j2=1 while confirm rises.
      do_reset();
      press(16'h1234);
      press(16'h5678);
      press(16'h8765);
      press(16'h0000);
      press(16'h1234);
      check("lit_pre_score_j2", int'(bus.score_j2), 1);
      press(16'h0000);
      press(16'h1234);
      press(16'h5678);
      press(16'h1243);
      check("lit_pre_reset_state", int'(bus.state), 5);
      @(negedge clock);
      reset       = 1'b1;
      bus.confirm = 1'b1;
      bus.guess   = 16'h2345;
      @(negedge clock);
      check("lit_rst_state",   int'(bus.state), 0);
      check("lit_rst_score",   int'(bus.score_j2), 0);
      check("lit_rst_starter", int'(bus.starter), 0);
      check("lit_rst_err",     int'(bus.err), 0);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("lit_held_after_reset", int'(bus.state), 0);
      bus.confirm = 1'b0;
      press(16'h2345);
      check("lit_after_release", int'(bus.state), 1);

      repeat (2) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
